// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle for countdown_timer_ctrl: strobes and levels in, registered count and flags out.
// No valid/ready pair here: Start and Clear are single-cycle strobes acted on at the next rising edge,
// Pause and AutoReload are levels sampled every edge, and every status output is a flop.
interface countdown_timer_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 Start;
    logic                 Pause;
    logic                 Clear;
    logic                 AutoReload;
    logic [CNT_WIDTH-1:0] LoadValue;
    logic [CNT_WIDTH-1:0] Out;
    logic                 Tick;
    logic                 Running;
    logic                 Done;
    logic                 Expired;
    logic [1:0]           state_dbg;

    modport master (
        output Start, Pause, Clear, AutoReload, LoadValue,
        input  Out, Tick, Running, Done, Expired, state_dbg
    );

    modport slave (
        input  Start, Pause, Clear, AutoReload, LoadValue,
        output Out, Tick, Running, Done, Expired, state_dbg
    );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer with built-in prescaler: one decrement per TICKS_PER_SEC clocks,
// pause/clear/restart control, one-shot or auto-reload, Done pulse and sticky Expired.
module countdown_timer_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int DIV_WIDTH     = 27,
    parameter int CNT_WIDTH     = 8
) (
    input logic                   Clock,
    input logic                   Reset,
    countdown_timer_ctrl_if.slave bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [DIV_WIDTH-1:0] PRESC_MAX  = DIV_WIDTH'(TICKS_PER_SEC - 1);
    localparam logic [DIV_WIDTH-1:0] PRESC_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] out_q, out_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;

    // Expiry step applied on the edge after a registered Tick; shared by RUN only.
    logic [1:0]           exp_state;
    logic [CNT_WIDTH-1:0] exp_out;
    logic                 exp_done;

    always_comb begin
        exp_state = ST_RUN;
        exp_out   = out_q;
        exp_done  = 1'b0;
        if (out_q > CNT_ONE) begin
            exp_out = out_q - CNT_ONE;
        end else if (out_q == CNT_ONE) begin
            exp_out  = CNT_ZERO;
            exp_done = 1'b1;
            if (!bus.AutoReload) begin
                exp_state = ST_EXPIRED;
            end
        end else if (bus.AutoReload) begin
            // Reloading zero counts as reaching zero again.
            exp_out  = bus.LoadValue;
            exp_done = (bus.LoadValue == CNT_ZERO);
        end else begin
            exp_state = ST_EXPIRED;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;

        if (bus.Clear) begin
            state_d = ST_IDLE;
            out_d   = CNT_ZERO;
            presc_d = PRESC_MAX;
        end else if (bus.Start) begin
            out_d   = bus.LoadValue;
            presc_d = PRESC_MAX;
            if (bus.LoadValue == CNT_ZERO) begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    presc_d = PRESC_MAX;
                end
                ST_RUN: begin
                    // A Tick already registered is always consumed, even if Pause rises now.
                    if (tick_q) begin
                        state_d = exp_state;
                        out_d   = exp_out;
                        done_d  = exp_done;
                    end
                    if (state_d == ST_EXPIRED) begin
                        presc_d = PRESC_MAX;
                    end else if (bus.Pause) begin
                        state_d = ST_PAUSED;
                    end else if (presc_q == PRESC_ZERO) begin
                        tick_d  = 1'b1;
                        presc_d = PRESC_MAX;
                    end else begin
                        presc_d = presc_q - 1'b1;
                    end
                end
                ST_PAUSED: begin
                    // Prescaler stays frozen on the resume edge and counts on from there.
                    if (!bus.Pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    out_d   = CNT_ZERO;
                    presc_d = PRESC_MAX;
                end
                default: begin
                    state_d = ST_IDLE;
                    out_d   = CNT_ZERO;
                    presc_d = PRESC_MAX;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            out_q   <= CNT_ZERO;
            presc_q <= PRESC_MAX;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign bus.Out       = out_q;
    assign bus.Tick      = tick_q;
    assign bus.Done      = done_q;
    assign bus.Running   = (state_q == ST_RUN);
    assign bus.Expired   = (state_q == ST_EXPIRED);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with TICKS_PER_SEC=4: expected output changes
// (cycle, Out, Tick, Done, Expired, Running) are queued and matched by a monitor.
module tb_countdown_timer_ctrl;
    localparam int TPS = 4;
    localparam int CW  = 8;
    localparam int W   = 28;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic [W-1:0] exp_q[$];

    countdown_timer_ctrl_if #(.CNT_WIDTH(CW)) bus();

    countdown_timer_ctrl #(
        .TICKS_PER_SEC(TPS),
        .DIV_WIDTH(3),
        .CNT_WIDTH(CW)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    // clock / cycle counter
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // expected change: signals take these values as seen just after posedge number c
    task automatic push_ev(input int c, input int o, input logic t, input logic d,
                           input logic e, input logic r);
        exp_q.push_back({c[15:0], o[7:0], t, d, e, r});
    endtask

    // Tick rises at c_tick; on the following edge Out moves and flags update.
    task automatic step(input int c_tick, input int o_before, input int o_after,
                        input logic d, input logic e, input logic r);
        push_ev(c_tick, o_before, 1'b1, 1'b0, 1'b0, 1'b1);
        push_ev(c_tick + 1, o_after, 1'b0, d, e, r);
        if (d) push_ev(c_tick + 2, o_after, 1'b0, 1'b0, e, r);
    endtask

    task automatic check1(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // park at the negedge just before edge c so inputs set now are captured at edge c
    task automatic goto(input int c);
        while (cyc < c - 1) @(negedge Clock);
    endtask

    task automatic strobe(input int c, input logic st, input logic cl,
                          input int lv, input logic ar);
        goto(c);
        bus.Start      = st;
        bus.Clear      = cl;
        bus.LoadValue  = lv[CW-1:0];
        bus.AutoReload = ar;
        @(negedge Clock);
        bus.Start = 1'b0;
        bus.Clear = 1'b0;
    endtask

    // monitor / scoreboard
    initial begin
        logic [4+CW-1:0] prev, cur;
        logic [W-1:0]    got, req;
        prev = '0;
        forever begin
            @(posedge Clock);
            #1;
            cur = {bus.Out, bus.Tick, bus.Done, bus.Expired, bus.Running};
            if (cur != prev) begin
                got = {cyc[15:0], cur};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event: got cyc=%0d out=%0d tick=%0b done=%0b exp=%0b run=%0b, required no change",
                             cyc, bus.Out, bus.Tick, bus.Done, bus.Expired, bus.Running);
                end else begin
                    req = exp_q.pop_front();
                    if (got != req) begin
                        failures++;
                        $display("FAIL event: got cyc=%0d out=%0d tick=%0b done=%0b exp=%0b run=%0b, required cyc=%0d out=%0d tick=%0b done=%0b exp=%0b run=%0b",
                                 got[27:12], got[11:4], got[3], got[2], got[1], got[0],
                                 req[27:12], req[11:4], req[3], req[2], req[1], req[0]);
                    end
                end
                prev = cur;
            end
        end
    end

    // driver
    initial begin
        int s1, s2, s3, c4, c5, c6, c7, c8;
        bus.Start = 1'b0;
        bus.Pause = 1'b0;
        bus.Clear = 1'b0;
        bus.AutoReload = 1'b0;
        bus.LoadValue = '0;

        #1 Reset = 1'b1;
        #2;
        check1("reset_out", int'(bus.Out), 0);
        check1("reset_flags", int'({bus.Tick, bus.Done, bus.Expired, bus.Running}), 0);
        check1("reset_state", int'(bus.state_dbg), 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // one-shot from 3
        s1 = cyc + 3;
        push_ev(s1, 3, 0, 0, 0, 1);
        step(s1 + 4, 3, 2, 0, 0, 1);
        step(s1 + 8, 2, 1, 0, 0, 1);
        step(s1 + 12, 1, 0, 1, 1, 0);
        strobe(s1, 1'b1, 1'b0, 3, 1'b0);

        // auto-reload from 2, restarted out of EXPIRED after 20 idle cycles, then cleared
        s2 = s1 + 34;
        push_ev(s2, 2, 0, 0, 0, 1);
        step(s2 + 4, 2, 1, 0, 0, 1);
        step(s2 + 8, 1, 0, 1, 0, 1);
        step(s2 + 12, 0, 2, 0, 0, 1);
        step(s2 + 16, 2, 1, 0, 0, 1);
        step(s2 + 20, 1, 0, 1, 0, 1);
        push_ev(s2 + 23, 0, 0, 0, 0, 0);
        strobe(s2, 1'b1, 1'b0, 2, 1'b1);
        strobe(s2 + 23, 1'b0, 1'b1, 2, 1'b1);

        // pause for 10 edges at Out=5 with 3 prescaler cycles left
        s3 = s2 + 26;
        push_ev(s3, 6, 0, 0, 0, 1);
        step(s3 + 4, 6, 5, 0, 0, 1);
        push_ev(s3 + 6, 5, 0, 0, 0, 0);
        push_ev(s3 + 16, 5, 0, 0, 0, 1);
        step(s3 + 19, 5, 4, 0, 0, 1);
        strobe(s3, 1'b1, 1'b0, 6, 1'b0);
        goto(s3 + 6);
        bus.Pause = 1'b1;
        goto(s3 + 16);
        bus.Pause = 1'b0;

        // restart at Out=4 with 9: full prescaler period before next decrement
        c4 = s3 + 21;
        push_ev(c4, 9, 0, 0, 0, 1);
        step(c4 + 4, 9, 8, 0, 0, 1);
        strobe(c4, 1'b1, 1'b0, 9, 1'b0);

        // Clear beats Start in the same cycle
        c5 = c4 + 6;
        push_ev(c5, 0, 0, 0, 0, 0);
        strobe(c5, 1'b1, 1'b1, 7, 1'b0);

        // Start with zero: immediate Done and EXPIRED even with AutoReload set
        c6 = c5 + 3;
        push_ev(c6, 0, 0, 1, 1, 0);
        push_ev(c6 + 1, 0, 0, 0, 1, 0);
        strobe(c6, 1'b1, 1'b0, 0, 1'b1);

        // asynchronous reset between edges during RUN
        c7 = c6 + 3;
        push_ev(c7, 5, 0, 0, 0, 1);
        step(c7 + 4, 5, 4, 0, 0, 1);
        push_ev(c7 + 7, 0, 0, 0, 0, 0);
        strobe(c7, 1'b1, 1'b0, 5, 1'b0);
        goto(c7 + 7);
        #2 Reset = 1'b1;
        #1;
        check1("async_reset_out", int'(bus.Out), 0);
        check1("async_reset_flags", int'({bus.Tick, bus.Done, bus.Expired, bus.Running}), 0);
        @(negedge Clock);
        Reset = 1'b0;

        // AutoReload dropped while sitting at 0: next Tick expires with no Done
        c8 = c7 + 10;
        push_ev(c8, 1, 0, 0, 0, 1);
        step(c8 + 4, 1, 0, 1, 0, 1);
        step(c8 + 8, 0, 0, 0, 1, 0);
        strobe(c8, 1'b1, 1'b0, 1, 1'b1);
        goto(c8 + 7);
        bus.AutoReload = 1'b0;

        repeat (20) @(negedge Clock);
        check1("pending_expected_events", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
